// File: rtl/exu_decode_stage.sv
// rtl/exu_decode_stage.sv - registered RV32I decode stage with skid buffer and flush
module exu_decode_stage #(
  parameter int NUM_LANES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_LANES-1:0]    in_lane_vld,
  input  logic [NUM_LANES*32-1:0] in_inst,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_LANES-1:0]    out_lane_vld,
  output logic [NUM_LANES*4-1:0]  out_opcode,
  output logic [NUM_LANES*5-1:0]  out_lsrc1,
  output logic [NUM_LANES*5-1:0]  out_lsrc2,
  output logic [NUM_LANES*5-1:0]  out_ldst,
  output logic [NUM_LANES-1:0]    out_src1_vld,
  output logic [NUM_LANES-1:0]    out_src2_vld,
  output logic [NUM_LANES-1:0]    out_dst_vld,
  output logic [NUM_LANES*32-1:0] out_imm,
  output logic [NUM_LANES-1:0]    out_illegal
);

  // Packed per-lane record:
  // [55] lane_vld, [54:51] opcode, [50:46] lsrc1, [45:41] lsrc2, [40:36] ldst,
  // [35] src1_vld, [34] src2_vld, [33] dst_vld, [32:1] imm, [0] illegal
  localparam int LW = 56;
  localparam int BW = NUM_LANES * LW;

  localparam logic [3:0] OP_NONE   = 4'd0;
  localparam logic [3:0] OP_LUI    = 4'd1;
  localparam logic [3:0] OP_AUIPC  = 4'd2;
  localparam logic [3:0] OP_JAL    = 4'd3;
  localparam logic [3:0] OP_JALR   = 4'd4;
  localparam logic [3:0] OP_BRANCH = 4'd5;
  localparam logic [3:0] OP_LOAD   = 4'd6;
  localparam logic [3:0] OP_STORE  = 4'd7;
  localparam logic [3:0] OP_ALUI   = 4'd8;
  localparam logic [3:0] OP_ALU    = 4'd9;
  localparam logic [3:0] OP_FENCE  = 4'd10;
  localparam logic [3:0] OP_ENV    = 4'd11;

  // Decode one instruction into the packed lane record; invalid lanes are all-zero.
  function automatic logic [LW-1:0] decode_lane(input logic vld, input logic [31:0] inst);
    logic [3:0]    op;
    logic          s1;
    logic          s2;
    logic          dv;
    logic          ill;
    logic [31:0]   imm;
    logic [LW-1:0] rec;
    case (inst[6:0])
      7'b0110111: op = OP_LUI;
      7'b0010111: op = OP_AUIPC;
      7'b1101111: op = OP_JAL;
      7'b1100111: op = OP_JALR;
      7'b1100011: op = OP_BRANCH;
      7'b0000011: op = OP_LOAD;
      7'b0100011: op = OP_STORE;
      7'b0010011: op = OP_ALUI;
      7'b0110011: op = OP_ALU;
      7'b0001111: op = OP_FENCE;
      7'b1110011: op = OP_ENV;
      default:    op = OP_NONE;
    endcase
    ill = (inst[1:0] != 2'b11) || (op == OP_NONE);
    s1  = !ill && (op inside {OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_ALUI, OP_ALU});
    s2  = !ill && (op inside {OP_BRANCH, OP_STORE, OP_ALU});
    dv  = !ill && (op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_ALUI, OP_ALU})
          && (inst[11:7] != 5'd0);
    case (op)
      OP_JALR, OP_LOAD, OP_ALUI: imm = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:                  imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:                 imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                                        inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:          imm = {inst[31:12], 12'b0};
      OP_JAL:                    imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                                        inst[30:21], 1'b0};
      default:                   imm = 32'd0;
    endcase
    if (ill) imm = 32'd0;
    rec = {1'b1, op, inst[19:15], inst[24:20], inst[11:7], s1, s2, dv, imm, ill};
    if (!vld) rec = '0;
    return rec;
  endfunction

  logic          m_vld;
  logic          s_vld;
  logic [BW-1:0] m_data;
  logic [BW-1:0] s_data;
  logic [BW-1:0] dec_data;
  logic          in_fire;
  logic          out_fire;
  logic          unused_inst;

  // funct3/funct7 are not needed by this stage; fold them so every input bit is consumed.
  assign unused_inst = ^in_inst;

  // Combinational decode of the offered bundle, one record per lane.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign dec_data[LW*i +: LW] = decode_lane(in_lane_vld[i], in_inst[32*i +: 32]);

    assign out_lane_vld[i]       = m_data[LW*i + 55];
    assign out_opcode[4*i +: 4]  = m_data[LW*i + 51 +: 4];
    assign out_lsrc1[5*i +: 5]   = m_data[LW*i + 46 +: 5];
    assign out_lsrc2[5*i +: 5]   = m_data[LW*i + 41 +: 5];
    assign out_ldst[5*i +: 5]    = m_data[LW*i + 36 +: 5];
    assign out_src1_vld[i]       = m_data[LW*i + 35];
    assign out_src2_vld[i]       = m_data[LW*i + 34];
    assign out_dst_vld[i]        = m_data[LW*i + 33];
    assign out_imm[32*i +: 32]   = m_data[LW*i + 1 +: 32];
    assign out_illegal[i]        = m_data[LW*i];
  end

  // Ready depends only on skid occupancy, so out_ready never reaches in_ready.
  assign in_ready  = !s_vld;
  assign out_valid = m_vld;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = m_vld && out_ready;

  // Main/skid register update: flush wins, then drain S into M, else load from input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_vld  <= 1'b0;
      s_vld  <= 1'b0;
      m_data <= '0;
      s_data <= '0;
    end else if (flush) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
    end else if (out_fire) begin
      if (s_vld) begin
        m_data <= s_data;
        s_vld  <= 1'b0;
      end else if (in_fire) begin
        m_data <= dec_data;
      end else begin
        m_vld <= 1'b0;
      end
    end else if (in_fire) begin
      if (!m_vld) begin
        m_data <= dec_data;
        m_vld  <= 1'b1;
      end else begin
        s_data <= dec_data;
        s_vld  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_exu_decode_stage.sv
// tb/tb_exu_decode_stage.sv - directed self-checking bench for exu_decode_stage
module tb_exu_decode_stage;

  localparam int NL = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [NL-1:0] in_lane_vld;
  logic [NL*32-1:0] in_inst;
  logic          out_valid;
  logic          out_ready;
  logic [NL-1:0] out_lane_vld;
  logic [NL*4-1:0] out_opcode;
  logic [NL*5-1:0] out_lsrc1;
  logic [NL*5-1:0] out_lsrc2;
  logic [NL*5-1:0] out_ldst;
  logic [NL-1:0] out_src1_vld;
  logic [NL-1:0] out_src2_vld;
  logic [NL-1:0] out_dst_vld;
  logic [NL*32-1:0] out_imm;
  logic [NL-1:0] out_illegal;

  int tests = 0;
  int errors = 0;

  exu_decode_stage #(.NUM_LANES(NL)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_vld(in_lane_vld), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lane_vld(out_lane_vld), .out_opcode(out_opcode),
    .out_lsrc1(out_lsrc1), .out_lsrc2(out_lsrc2), .out_ldst(out_ldst),
    .out_src1_vld(out_src1_vld), .out_src2_vld(out_src2_vld), .out_dst_vld(out_dst_vld),
    .out_imm(out_imm), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] i1, input logic [31:0] i0);
    in_valid    = 1'b1;
    in_lane_vld = 2'b11;
    in_inst     = {i1, i0};
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_lane_vld = '0; in_inst = '0;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_imm0", out_imm[31:0], 32'd0);
    rst = 1'b0;
    step();

    // addi x5,x6,-1 / sw x7,8(x2)
    offer(32'h00712423, 32'hFFF30293);
    step();
    in_valid = 1'b0;
    check("t1_out_valid", {31'd0, out_valid}, 32'd1);
    check("t1_l0_op", {28'd0, out_opcode[3:0]}, 32'd8);
    check("t1_l0_lsrc1", {27'd0, out_lsrc1[4:0]}, 32'd6);
    check("t1_l0_ldst", {27'd0, out_ldst[4:0]}, 32'd5);
    check("t1_l0_vlds", {29'd0, out_src1_vld[0], out_src2_vld[0], out_dst_vld[0]}, 32'b101);
    check("t1_l0_imm", out_imm[31:0], 32'hFFFFFFFF);
    check("t1_l1_op", {28'd0, out_opcode[7:4]}, 32'd7);
    check("t1_l1_lsrc1", {27'd0, out_lsrc1[9:5]}, 32'd2);
    check("t1_l1_lsrc2", {27'd0, out_lsrc2[9:5]}, 32'd7);
    check("t1_l1_dst_vld", {31'd0, out_dst_vld[1]}, 32'd0);
    check("t1_l1_imm", out_imm[63:32], 32'h00000008);
    check("t1_illegal", {30'd0, out_illegal}, 32'd0);
    step();
    check("t1_drain", {31'd0, out_valid}, 32'd0);

    // Illegal encodings
    offer(32'h0000007F, 32'h00000000);
    step();
    in_valid = 1'b0;
    check("ill_lane_vld", {30'd0, out_lane_vld}, 32'b11);
    check("ill_flag", {30'd0, out_illegal}, 32'b11);
    check("ill_op", {24'd0, out_opcode}, 32'd0);
    check("ill_vlds", {26'd0, out_src1_vld, out_src2_vld, out_dst_vld}, 32'd0);
    check("ill_imm0", out_imm[31:0], 32'd0);
    check("ill_imm1", out_imm[63:32], 32'd0);

    // lui x0 in lane0; lane1 invalid carrying an addi
    offer(32'hFFF30293, 32'h12345037);
    in_lane_vld = 2'b01;
    step();
    in_valid = 1'b0;
    check("lui_op", {28'd0, out_opcode[3:0]}, 32'd1);
    check("lui_dst_vld", {31'd0, out_dst_vld[0]}, 32'd0);
    check("lui_imm", out_imm[31:0], 32'h12345000);
    check("inv_lane_vld", {31'd0, out_lane_vld[1]}, 32'd0);
    check("inv_fields", {out_opcode[7:4], out_lsrc1[9:5], out_lsrc2[9:5], out_ldst[9:5],
                         out_src1_vld[1], out_src2_vld[1], out_dst_vld[1], out_illegal[1]}, 32'd0);
    check("inv_imm", out_imm[63:32], 32'd0);

    // beq x1,x2,-4 / jal x1,8
    offer(32'h008000EF, 32'hFE208EE3);
    step();
    in_valid = 1'b0;
    check("beq_op", {28'd0, out_opcode[3:0]}, 32'd5);
    check("beq_vlds", {29'd0, out_src1_vld[0], out_src2_vld[0], out_dst_vld[0]}, 32'b110);
    check("beq_imm", out_imm[31:0], 32'hFFFFFFFC);
    check("jal_op", {28'd0, out_opcode[7:4]}, 32'd3);
    check("jal_dst_vld", {31'd0, out_dst_vld[1]}, 32'd1);
    check("jal_imm", out_imm[63:32], 32'h00000008);
    step();

    // Backpressure: A,B,C tagged by addi immediates 1,2,3
    out_ready = 1'b0;
    offer(32'h00100093, 32'h00100093);
    step();
    check("bp_a_out", out_imm[31:0], 32'd1);
    offer(32'h00200093, 32'h00200093);
    step();
    check("bp_a_hold1", out_imm[31:0], 32'd1);
    check("bp_in_ready0", {31'd0, in_ready}, 32'd0);
    offer(32'h00300093, 32'h00300093);
    step();
    check("bp_a_hold2", out_imm[31:0], 32'd1);
    check("bp_valid_hold", {31'd0, out_valid}, 32'd1);
    check("bp_in_ready0b", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    step();
    check("bp_b_out", out_imm[31:0], 32'd2);
    check("bp_in_ready1", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("bp_c_out", out_imm[31:0], 32'd3);
    check("bp_c_valid", {31'd0, out_valid}, 32'd1);
    step();
    check("bp_empty", {31'd0, out_valid}, 32'd0);

    // Flush with M and S full and an input offered
    out_ready = 1'b0;
    offer(32'h00400093, 32'h00400093);
    step();
    offer(32'h00500093, 32'h00500093);
    step();
    check("fl_s_full", {31'd0, in_ready}, 32'd0);
    offer(32'h00600093, 32'h00600093);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("fl_out_valid", {31'd0, out_valid}, 32'd0);
    check("fl_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("fl_dropped", {31'd0, out_valid}, 32'd0);

    // Flush drops an input even when in_ready=1
    offer(32'h00700093, 32'h00700093);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl2_out_valid", {31'd0, out_valid}, 32'd0);
    step();
    check("fl2_dropped", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset with M and S full
    out_ready = 1'b0;
    offer(32'h00800093, 32'h00800093);
    step();
    offer(32'h00900093, 32'h00900093);
    step();
    in_valid = 1'b0;
    check("rs_pre_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("rs_out_valid", {31'd0, out_valid}, 32'd0);
    check("rs_in_ready", {31'd0, in_ready}, 32'd1);
    check("rs_imm", out_imm[31:0], 32'd0);
    check("rs_fields", {out_lane_vld, out_opcode, out_lsrc1, out_ldst, out_dst_vld}, 32'd0);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    offer(32'h00A00093, 32'h00A00093);
    step();
    in_valid = 1'b0;
    check("rs_first_valid", {31'd0, out_valid}, 32'd1);
    check("rs_first_imm", out_imm[31:0], 32'd10);
    step();
    check("rs_no_stale", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/exu_decode_stage.md
Name: exu_decode_stage

Overview:
Parametrised, registered decode stage for the EXU front end.
- Accepts a bundle of NUM_LANES 32-bit RV32I instructions per handshake.
- Per lane, produces the uop class, logical register indices with use-valids, a sign-extended immediate, and an illegal flag.
- Sits between fetch/instruction buffer and rename. Has valid/ready flow control, a one-entry skid buffer for full throughput under backpressure, and a pipeline flush.

Parameters:
NUM_LANES, 2, instructions decoded per bundle (1..4)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous kill of all buffered bundles
in_valid  input  1  input bundle valid
in_ready  output  1  stage can accept a bundle
in_lane_vld  input  NUM_LANES  per-lane instruction valid
in_inst  input  NUM_LANES*32  instructions, lane i at [32i+31:32i]
out_valid  output  1  output bundle valid
out_ready  input  1  downstream accepts bundle
out_lane_vld  output  NUM_LANES  per-lane valid
out_opcode  output  NUM_LANES*4  uop class
out_lsrc1/out_lsrc2/out_ldst  output  NUM_LANES*5 each  rs1/rs2/rd fields
out_src1_vld/out_src2_vld/out_dst_vld  output  NUM_LANES each  register-use flags
out_imm  output  NUM_LANES*32  sign-extended immediate
out_illegal  output  NUM_LANES  illegal encoding

Behaviour:
- Uop class encoding (4 bits):
  - NONE=0, LUI=1, AUIPC=2, JAL=3, JALR=4, BRANCH=5, LOAD=6, STORE=7, ALUI=8, ALU=9, FENCE=10, ENV=11.
  - Decoded from inst[6:0]: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011.
  - Any other value decodes to NONE.
- Register fields: lsrc1=inst[19:15], lsrc2=inst[24:20], ldst=inst[11:7]. They are always driven, regardless of the use flags.
  - src1_vld: JALR, BRANCH, LOAD, STORE, ALUI, ALU.
  - src2_vld: BRANCH, STORE, ALU.
  - dst_vld: LUI, AUIPC, JAL, JALR, LOAD, ALUI, ALU, and only when ldst!=0.
- Immediate, sign-extended from inst[31]:
  - I-type: JALR, LOAD, ALUI.
  - S-type: STORE.
  - B-type: BRANCH, bit0=0.
  - U-type: LUI, AUIPC, low 12 bits zero.
  - J-type: JAL, bit0=0.
  - All other classes: 0.
- Illegal: lane valid AND (inst[1:0]!=2'b11 OR class==NONE). An illegal lane still outputs lane_vld=1, with all use-valids 0 and imm 0.
- Invalid lanes (in_lane_vld=0): all decoded fields and flags are forced to 0.
- Storage: main output register M plus skid register S, each holding a full decoded bundle and a valid bit.
  - in_ready = !S.valid (registered-state only; no combinational path from out_ready).
  - Input fire = in_valid & in_ready; output fire = out_valid & out_ready.
  - Latency: 1 cycle from input fire to out_valid.
  - out_valid=M.valid. All out_* are driven from M and held stable while out_valid & !out_ready.
  - Output fire with S valid: S→M, S cleared.
  - Output fire with S empty and input fire: new bundle→M.
  - M empty: input fire loads M.
  - M valid, no output fire, input fire: new bundle→S (in_ready drops next cycle).
  - Output fire, no input fire, S empty: M.valid←0.
  - Sustained in_valid & out_ready: one bundle per cycle, no bubbles.
- Ordering: bundles leave in acceptance order.
- Flush has priority over all updates: M.valid←0, S.valid←0. An input offered in the flush cycle is dropped, even if in_ready=1.
- Reset (asynchronous, any cycle including mid-transfer):
  - M.valid=S.valid=0, so out_valid=0 and in_ready=1 from the next edge after deassertion.
  - All out_* data fields reset to 0.
- Data registers update only on load; no other state exists.

Test Plan:
- Reset, NUM_LANES=2: lane0=0xFFF30293 (addi x5,x6,-1), lane1=0x00712423 (sw x7,8(x2)), both valid, out_ready=1.
  - Next cycle out_valid=1.
  - Lane0: opcode=8, lsrc1=6, ldst=5, src1_vld=1, src2_vld=0, dst_vld=1, imm=0xFFFFFFFF.
  - Lane1: opcode=7, lsrc1=2, lsrc2=7, dst_vld=0, imm=0x00000008.
- Inst 0x00000000 and 0x0000007F, lane valid.
  - illegal=1, opcode=0, all use-valids 0, imm=0.
- lui x0,0x12345 (0x12345037).
  - opcode=1, dst_vld=0, imm=0x12345000.
- Backpressure: stream bundles A,B,C back-to-back; hold out_ready=0 for 3 cycles.
  - A stable on outputs, B captured in S, in_ready=0.
  - On release, output order is A,B,C with no loss or duplication.
  - in_ready returns to 1 one cycle after A leaves.
- Flush with M and S both full and in_valid=1.
  - Next cycle out_valid=0, in_ready=1.
  - The offered bundle never appears on the output.
- Assert rst while out_valid=1 and S full.
  - Immediately out_valid=0 and all out_* = 0.
  - After release, the first accepted bundle emerges with 1-cycle latency.
